// File: rtl/seq_or_checker.sv
// seq_or_checker: passive monitor for ((br_start[i], v=br_val[i]) ##br_dly[i] br_chk[i]==v) or ... ##1 end_data==v; ports: clk/rst/en, br_* per-branch launch/check inputs, end_data, pass_o/pass_br/fail_o pulses, pass_cnt/fail_cnt saturating counters
module seq_or_checker #(
  parameter int NUM_BR = 2,
  parameter int DATA_W = 32,
  parameter int MAX_DLY = 4,
  parameter int DLY_W = 4,
  parameter int CNT_W = 16,
  localparam int BR_W = NUM_BR > 1 ? $clog2(NUM_BR) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic [NUM_BR-1:0]        br_start,
  input  logic [NUM_BR*DATA_W-1:0] br_val,
  input  logic [NUM_BR*DLY_W-1:0]  br_dly,
  input  logic [NUM_BR*DATA_W-1:0] br_chk,
  input  logic [DATA_W-1:0]        end_data,
  output logic                     pass_o,
  output logic [BR_W-1:0]          pass_br,
  output logic                     fail_o,
  output logic [CNT_W-1:0]         pass_cnt,
  output logic [CNT_W-1:0]         fail_cnt
);
  localparam int D = MAX_DLY + 2;
  localparam longint CMAX = (longint'(1) << CNT_W) - 1;
  logic [NUM_BR-1:0] live [D];
  logic [NUM_BR-1:0] nlive [D];
  logic done [D];
  logic ndone [D];
  logic [NUM_BR*DATA_W-1:0] v [D];
  logic [NUM_BR*DLY_W-1:0] dl [D];
  logic [NUM_BR*DLY_W-1:0] ld;
  logic pv;
  logic [BR_W-1:0] pb;
  int pn, fn;
  always_comb begin
    ld = '0;
    for (int i = 0; i < NUM_BR; i++)
      ld[i*DLY_W +: DLY_W] = br_dly[i*DLY_W +: DLY_W] == '0 ? DLY_W'(1) :
                             int'(br_dly[i*DLY_W +: DLY_W]) > MAX_DLY ? DLY_W'(MAX_DLY) :
                             br_dly[i*DLY_W +: DLY_W];
  end
  // slot j holds the attempt launched j+1 cycles ago; a thread checks br_chk at age d and end_data at age d+1
  always_comb begin
    logic [NUM_BR-1:0] m, s;
    logic cj;
    m = '0;
    s = '0;
    cj = 1'b0;
    pv = 1'b0;
    pb = '0;
    pn = 0;
    fn = 0;
    for (int k = 0; k < D; k++) begin
      nlive[k] = '0;
      ndone[k] = 1'b1;
    end
    nlive[0] = en ? br_start : '0;
    ndone[0] = !(en && |br_start);
    for (int j = 0; j < D; j++) begin
      m = live[j];
      s = '0;
      for (int i = 0; i < NUM_BR; i++) begin
        if (live[j][i] && int'(dl[j][i*DLY_W +: DLY_W]) == j + 1 &&
            br_chk[i*DATA_W +: DATA_W] != v[j][i*DATA_W +: DATA_W])
          m[i] = 1'b0;
        if (live[j][i] && int'(dl[j][i*DLY_W +: DLY_W]) == j) begin
          m[i] = 1'b0;
          s[i] = end_data == v[j][i*DATA_W +: DATA_W];
        end
      end
      cj = !done[j] && (|s || m == '0);
      // ascending age scan lets the oldest passing attempt overwrite pb last
      if (cj && |s) begin
        pv = 1'b1;
        pn++;
        for (int i = NUM_BR - 1; i >= 0; i--)
          if (s[i]) pb = BR_W'(i);
      end
      if (cj && !(|s)) fn++;
      if (j < D - 1) begin
        nlive[j+1] = |s ? '0 : m;
        ndone[j+1] = done[j] || cj;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      pass_o <= 1'b0;
      fail_o <= 1'b0;
      pass_br <= '0;
      pass_cnt <= '0;
      fail_cnt <= '0;
      for (int j = 0; j < D; j++) begin
        live[j] <= '0;
        done[j] <= 1'b1;
        v[j] <= '0;
        dl[j] <= '0;
      end
    end else begin
      pass_o <= pv;
      fail_o <= fn != 0;
      pass_br <= pb;
      pass_cnt <= longint'(pass_cnt) + longint'(pn) > CMAX ? '1 : pass_cnt + CNT_W'(pn);
      fail_cnt <= longint'(fail_cnt) + longint'(fn) > CMAX ? '1 : fail_cnt + CNT_W'(fn);
      v[0] <= br_val;
      dl[0] <= ld;
      for (int j = 0; j < D; j++) begin
        live[j] <= nlive[j];
        done[j] <= ndone[j];
      end
      for (int j = 1; j < D; j++) begin
        v[j] <= v[j-1];
        dl[j] <= dl[j-1];
      end
    end
  end
endmodule

// File: tb/tb_seq_or_checker.sv
// tb_seq_or_checker: directed bench for seq_or_checker with NUM_BR=2, MAX_DLY=4, CNT_W=4
module tb_seq_or_checker;
  logic clk = 1'b0;
  logic rst, en;
  logic [1:0] br_start;
  logic [63:0] br_val, br_chk;
  logic [7:0] br_dly;
  logic [31:0] end_data;
  logic pass_o, fail_o;
  logic [0:0] pass_br;
  logic [3:0] pass_cnt, fail_cnt;
  int ncmp = 0;
  int nerr = 0;
  seq_or_checker #(.NUM_BR(2), .DATA_W(32), .MAX_DLY(4), .DLY_W(4), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .en(en), .br_start(br_start), .br_val(br_val),
    .br_dly(br_dly), .br_chk(br_chk), .end_data(end_data), .pass_o(pass_o),
    .pass_br(pass_br), .fail_o(fail_o), .pass_cnt(pass_cnt), .fail_cnt(fail_cnt)
  );
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    ncmp++;
    assert (got === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic idle;
    br_start = 2'b00;
    br_chk = '0;
    end_data = '0;
  endtask
  initial begin
    rst = 1'b1;
    en = 1'b0;
    br_start = 2'b00;
    br_val = '0;
    br_chk = '0;
    br_dly = {4'd2, 4'd1};
    end_data = '0;
    tick;
    tick;
    chk("rst_pass_o", pass_o, 0);
    chk("rst_fail_o", fail_o, 0);
    chk("rst_pass_br", pass_br, 0);
    chk("rst_pass_cnt", pass_cnt, 0);
    chk("rst_fail_cnt", fail_cnt, 0);
    rst = 1'b0;
    en = 1'b1;
    br_start = 2'b01;
    br_val[31:0] = 32'd1;
    tick;
    chk("t1_c1_pass", pass_o, 0);
    br_start = 2'b00;
    br_chk[31:0] = 32'd1;
    tick;
    chk("t1_c2_pass", pass_o, 0);
    end_data = 32'd1;
    tick;
    chk("t1_pass_o", pass_o, 1);
    chk("t1_pass_br", pass_br, 0);
    chk("t1_pass_cnt", pass_cnt, 1);
    chk("t1_fail_o", fail_o, 0);
    idle;
    tick;
    chk("t1_pulse_end", pass_o, 0);
    br_start = 2'b01;
    tick;
    br_start = 2'b00;
    br_chk[31:0] = 32'd1;
    tick;
    end_data = 32'd5;
    tick;
    chk("t2_fail_o", fail_o, 1);
    chk("t2_fail_cnt", fail_cnt, 1);
    chk("t2_pass_o", pass_o, 0);
    chk("t2_pass_cnt", pass_cnt, 1);
    idle;
    tick;
    br_start = 2'b11;
    br_val = {32'd2, 32'd1};
    tick;
    br_start = 2'b00;
    br_chk = {32'd0, 32'd9};
    tick;
    br_chk = {32'd2, 32'd0};
    tick;
    chk("t3_c3_pass", pass_o, 0);
    chk("t3_c3_fail", fail_o, 0);
    br_chk = '0;
    end_data = 32'd2;
    tick;
    chk("t3_pass_o", pass_o, 1);
    chk("t3_pass_br", pass_br, 1);
    chk("t3_fail_o", fail_o, 0);
    chk("t3_pass_cnt", pass_cnt, 2);
    idle;
    tick;
    chk("t3_no_late_fail", fail_o, 0);
    br_start = 2'b11;
    br_val = {32'd3, 32'd3};
    tick;
    br_start = 2'b00;
    br_chk = {32'd0, 32'd3};
    tick;
    br_chk = {32'd3, 32'd0};
    end_data = 32'd3;
    tick;
    chk("t4_pass_o", pass_o, 1);
    chk("t4_pass_br", pass_br, 0);
    chk("t4_pass_cnt", pass_cnt, 3);
    br_chk = '0;
    tick;
    chk("t4_no_second_pass", pass_o, 0);
    chk("t4_no_fail", fail_o, 0);
    chk("t4_pass_cnt_hold", pass_cnt, 3);
    idle;
    tick;
    br_start = 2'b10;
    br_val = {32'd7, 32'd0};
    tick;
    br_start = 2'b01;
    br_val = {32'd0, 32'd7};
    tick;
    br_start = 2'b00;
    br_chk = {32'd7, 32'd7};
    tick;
    chk("t5_c3_pass", pass_o, 0);
    br_chk = '0;
    end_data = 32'd7;
    tick;
    chk("t5_pass_o", pass_o, 1);
    chk("t5_pass_br", pass_br, 1);
    chk("t5_pass_cnt", pass_cnt, 5);
    chk("t5_fail_o", fail_o, 0);
    idle;
    tick;
    chk("t5_pulse_end", pass_o, 0);
    br_dly = {4'd2, 4'd0};
    br_start = 2'b01;
    br_val = {32'd0, 32'd6};
    tick;
    br_start = 2'b00;
    br_chk = {32'd0, 32'd6};
    tick;
    br_chk = '0;
    end_data = 32'd6;
    tick;
    chk("dly0_pass_o", pass_o, 1);
    chk("dly0_pass_cnt", pass_cnt, 6);
    idle;
    br_dly = {4'd9, 4'd1};
    br_start = 2'b10;
    br_val = {32'd8, 32'd0};
    tick;
    br_start = 2'b00;
    tick;
    tick;
    tick;
    chk("clamp_early_fail", fail_o, 0);
    br_chk = {32'd8, 32'd0};
    tick;
    chk("clamp_early_pass", pass_o, 0);
    br_chk = '0;
    end_data = 32'd8;
    tick;
    chk("clamp_pass_o", pass_o, 1);
    chk("clamp_pass_br", pass_br, 1);
    chk("clamp_pass_cnt", pass_cnt, 7);
    chk("clamp_fail_cnt", fail_cnt, 1);
    idle;
    br_dly = {4'd2, 4'd1};
    tick;
    br_start = 2'b01;
    br_val = {32'd0, 32'd4};
    tick;
    rst = 1'b1;
    br_start = 2'b00;
    br_chk = {32'd0, 32'd4};
    tick;
    chk("t6_rst_pass_cnt", pass_cnt, 0);
    chk("t6_rst_fail_cnt", fail_cnt, 0);
    chk("t6_rst_pass_o", pass_o, 0);
    rst = 1'b0;
    br_chk = '0;
    end_data = 32'd4;
    tick;
    chk("t6_post_pass_o", pass_o, 0);
    chk("t6_post_fail_o", fail_o, 0);
    end_data = '0;
    tick;
    tick;
    chk("t6_quiet_pass_o", pass_o, 0);
    chk("t6_quiet_fail_o", fail_o, 0);
    chk("t6_quiet_pass_cnt", pass_cnt, 0);
    chk("t6_quiet_fail_cnt", fail_cnt, 0);
    br_start = 2'b01;
    br_val = {32'd0, 32'd1};
    br_chk = '0;
    for (int k = 1; k <= 18; k++) begin
      tick;
      chk($sformatf("sat_fail_cnt_%0d", k), fail_cnt, (k - 1 > 15) ? 15 : k - 1);
      chk($sformatf("sat_fail_o_%0d", k), fail_o, k >= 2);
    end
    chk("sat_pass_cnt", pass_cnt, 0);
    idle;
    en = 1'b0;
    tick;
    tick;
    chk("sat_hold", fail_cnt, 15);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule

// File: doc/seq_or_checker.md
# seq_or_checker

Synthesizable run-time checker for an N-branch `or` sequence with per-thread local variables. Each branch captures a local value at launch, checks a branch data field after a per-branch delay, then checks a common end condition one cycle later. It replaces hand-written SVA for `((a_i, v=val_i) ##dly_i chk_i==v) or ... ##1 e==v`, so the same property can run on emulation and FPGA builds. It sits beside the DUT as a passive monitor and feeds pass/fail pulses and counters to the status block.

## Interface
- `NUM_BR`, 2: number of `or` branches (1..8).
- `DATA_W`, 32: width of local variable, branch check data and end data.
- `MAX_DLY`, 4: maximum branch delay in cycles (1..15).
- `DLY_W`, 4: width of each delay field; must hold `MAX_DLY`.
- `CNT_W`, 16: width of pass/fail counters.
- `clk`  in  1  sole clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `en`  in  1  launch enable; 0 blocks new attempts, in-flight threads continue.
- `br_start`  in  NUM_BR  per-branch first-element condition (the `a`/`c` term).
- `br_val`  in  NUM_BR*DATA_W  value assigned to the local variable on launch.
- `br_dly`  in  NUM_BR*DLY_W  per-branch delay (the `##dly`).
- `br_chk`  in  NUM_BR*DATA_W  per-branch check data compared with the local value.
- `end_data`  in  DATA_W  common end term (`e`), compared one cycle after the branch check.
- `pass_o`  out  1  at least one attempt passed this cycle.
- `pass_br`  out  $clog2(NUM_BR) or 1  winning branch of the oldest attempt passing this cycle.
- `fail_o`  out  1  at least one attempt failed this cycle.
- `pass_cnt`, `fail_cnt`  out  CNT_W  saturating attempt counters.

## Operation
- Attempt launch at cycle t: `en && |br_start`. Each branch i with `br_start[i]` spawns a thread that holds v_i=`br_val[i]` and d_i=`br_dly[i]`. A value of 0 is treated as 1, and values above `MAX_DLY` are clamped to `MAX_DLY`. The local value and delay are latched at launch, so later input changes do not affect the thread.
- Thread i, stage 1: at t+d_i, if `br_chk[i] != v_i` the thread dies.
- Thread i, stage 2: at t+d_i+1, the thread succeeds if `end_data == v_i`; otherwise it dies.
- Attempt pass: the first cycle in which any of its threads succeeds.
  - The attempt is reported once. Its remaining threads are cancelled.
  - If several threads of one attempt succeed in the same cycle, the lowest branch index wins.
- Attempt fail: the cycle in which its last live thread dies with no success.
- Attempt tracking: per-age slot shift register of depth `MAX_DLY+2`. Each slot holds a live-thread mask, per-branch v and d, and a done flag.
- Multiple attempts (different launch cycles) can conclude in the same cycle:
  - `pass_o` and `fail_o` may both be 1.
  - `pass_br` reports the oldest passing attempt.
  - Each counter increments by the number of attempts concluding that way, saturating at all-ones.
- Overlapping attempts are independent. There is no back-pressure; throughput is one attempt per cycle.

## Timing
- Reset values: `pass_o`=0, `fail_o`=0, `pass_br`=0, `pass_cnt`=0, `fail_cnt`=0. All slots are cleared.
- Reset asserted mid-operation discards every in-flight attempt with no pass/fail report. The first launch is sampled on the cycle after `rst` deasserts.
- Outputs are registered. A verdict decided by samples at cycle k appears at k+1.
  - Pass latency is d_i+2 cycles from launch.
  - Fail latency is (death cycle of last thread)+1.
- `pass_o` and `fail_o` are single-cycle pulses per concluding cycle. Counters update in the same cycle as the pulses.

## Test plan
1. NUM_BR=2, dly={1,2}. Launch t=0 with only `br_start[0]`, v=1. Drive `br_chk[0]`=1 at t=1 and `end_data`=1 at t=2 -> `pass_o`=1 at t=3, `pass_br`=0, `pass_cnt`=1.
2. Same launch but `end_data`=5 at t=2 -> `fail_o`=1 at t=3, `fail_cnt`=1, no pass.
3. Both branches at t=0, v0=1, v1=2. Branch0 `br_chk`=9 at t=1 (dies); branch1 `br_chk`=2 at t=2 and `end_data`=2 at t=3 -> single `pass_o` at t=4 with `pass_br`=1, and no `fail_o`.
4. Both branches succeed and branch0 concludes first (t=2). Branch1 would also succeed at t=3 -> exactly one pass at t=3 with `pass_br`=0, and no second pass at t=4.
5. Back-to-back attempts at t=0 and t=1 with dly 2 and dly 1 -> both conclude at t=3. Check `pass_o`=1, `pass_cnt` increments by 2, and `pass_br` is that of the t=0 attempt.
6. Launch at t=0, then `rst` at t=1 -> no pulses ever. Counters held at 0 until the first post-reset attempt, then `fail_cnt` saturates after 2^CNT_W-1 forced failures with CNT_W=4.
